rca_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer that performs WIDTH-bit additions on one shared RCA_4
//  4-bit ripple-carry adder, one nibble per clock, LSB slice first.
//  A registered carry links each slice to the next.

---
 rtl/rca_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_rca_seq_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// Sequential WIDTH-bit adder: one shared 4-bit ripple-carry slice, one nibble per clock,
// LSB first, with a registered carry linking consecutive slices.

module RCA_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

module rca_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [3:0]       s4;
  logic             c4;
  logic             last;

  RCA_4 u_rca (
    .a    (a_q[4*idx_q +: 4]),
    .b    (b_q[4*idx_q +: 4]),
    .cin  (carry_q),
    .sum  (s4),
    .cout (c4)
  );

  assign last = (idx_q == IW'(NSLICE - 1));

  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        start_ready = 1'b1;
        if (start_valid) state_d = StAdd;
      end
      StAdd: begin
        busy = 1'b1;
        if (last) state_d = StDone;
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          // sum/cout hold the previous result until the first ADD cycle
          if (start_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        StAdd: begin
          sum[4*idx_q +: 4] <= s4;
          carry_q           <= c4;
          if (last) cout <= c4;
          else      idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl: scoreboard of a+b+cin checked at each done pulse,
// plus handshake, latency, reset-abort and back-to-back checks.

module tb_rca_seq_ctrl;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done;
  logic             busy;

  int total = 0;
  int bad   = 0;
  logic [WIDTH:0] sb_q[$];

  rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sum         (sum),
    .cout        (cout),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge while idle; operands are scrambled after accept.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic tc);
    check("ready_before_issue", 32'(start_ready), 32'd1);
    a = ta; b = tb_v; cin = tc; start_valid = 1'b1;
    sb_q.push_back({1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tc});
    @(negedge clk);
    start_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
  endtask

  // Wait (bounded) for done; check latency, handshake during ADD, and the result.
  task automatic run_done(input string tag, input int exp_lat);
    int  lat;
    bit  seen;
    logic [WIDTH:0] exp;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      else begin
        check({tag, "_ready_in_add"}, 32'(start_ready), 32'd0);
        check({tag, "_busy_in_add"}, 32'(busy), 32'd1);
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (seen) begin
      check({tag, "_ready_in_done"}, 32'(start_ready), 32'd0);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check({tag, "_sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(exp[WIDTH]));
      end else check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      @(negedge clk);
      check({tag, "_done_single"}, 32'(done), 32'd0);
      check({tag, "_ready_after"}, 32'(start_ready), 32'd1);
    end
  endtask

  task automatic no_done(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check(tag, 32'(n), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] opa[2];
    logic [WIDTH-1:0] opb[2];
    logic             opc[2];
    int               acc_cyc[2];
    int               acc_n, dn, cyc;
    bit               sw;
    logic [WIDTH:0]   exp;

    rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T1..T3
    issue(16'h0003, 16'h000A, 1'b0);
    run_done("t1", 4);
    check("t1_literal", 32'({cout, sum}), 32'h0000D);
    issue(16'hFFFF, 16'h0001, 1'b0);
    run_done("t2", 4);
    check("t2_literal", 32'({cout, sum}), 32'h10000);
    issue(16'h0F0F, 16'h00F0, 1'b1);
    run_done("t3", 4);
    check("t3_literal", 32'({cout, sum}), 32'h01000);

    // T4: stray request during ADD is ignored
    issue(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; cin = 1'b1; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    run_done("t4", 2);
    no_done("t4_no_extra_done", 8);

    // T5: reset on the 2nd ADD cycle abandons the operation
    issue(16'h8000, 16'h8000, 1'b0);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    no_done("t5_no_done", 8);
    issue(16'h8000, 16'h8000, 1'b0);
    run_done("t5b", 4);

    // T6: start_valid held high across two operations
    opa[0] = 16'hABCD; opb[0] = 16'h1234; opc[0] = 1'b1;
    opa[1] = 16'h7FFF; opb[1] = 16'h8001; opc[1] = 1'b0;
    acc_n = 0; dn = 0; sw = 1'b0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    a = opa[0]; b = opb[0]; cin = opc[0]; start_valid = 1'b1;
    for (cyc = 0; cyc < 30; cyc++) begin
      if (done) begin
        dn++;
        if (sb_q.size() > 0) begin
          exp = sb_q.pop_front();
          check("t6_result", 32'({cout, sum}), 32'(exp));
        end else check("t6_sb_underflow", 32'(sb_q.size()), 32'd1);
      end
      if (sw) begin
        sw = 1'b0;
        if (acc_n < 2) begin
          a = opa[acc_n]; b = opb[acc_n]; cin = opc[acc_n];
        end else start_valid = 1'b0;
      end
      if (start_valid && start_ready) begin
        sb_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
        if (acc_n < 2) acc_cyc[acc_n] = cyc;
        acc_n++;
        sw = 1'b1;
      end
      @(negedge clk);
    end
    start_valid = 1'b0;
    check("t6_accepts", 32'(acc_n), 32'd2);
    check("t6_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    check("t6_dones", 32'(dn), 32'd2);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
